// File: rtl/kernel_kcore_degree_update.sv
// kcore degree update stage: pops neighbour vertex IDs, decrements their
// degree in a local RAM and forwards vertices whose degree crosses below k.
module kernel_kcore_degree_update #(
    parameter int VID_W = 10,
    parameter int DEG_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DEG_W-1:0] k_value,
    input  logic             init_we,
    input  logic [VID_W-1:0] init_addr,
    input  logic [DEG_W-1:0] init_deg,
    input  logic             in_empty_n,
    output logic             in_read,
    input  logic [63:0]      in_dout,
    input  logic             out_full_n,
    output logic             out_write,
    output logic [63:0]      out_din,
    output logic             busy,
    output logic             done,
    output logic [31:0]      peel_count
);

    typedef enum logic [1:0] {S_FETCH, S_READ, S_UPD, S_EMIT} state_t;

    localparam logic [63:0] MARKER_WORD = 64'h8000_0000_0000_0000;

    state_t           state_q;
    logic [VID_W-1:0] vid_q;
    logic             mark_q;
    logic [63:0]      out_din_q;
    logic [31:0]      peel_q;

    logic [DEG_W-1:0] mem_q [2**VID_W];
    logic [DEG_W-1:0] rdata_q;

    logic             ram_we;
    logic [VID_W-1:0] ram_addr;
    logic [DEG_W-1:0] ram_wdata;

    logic             fetch_go;
    logic [DEG_W-1:0] new_deg;
    logic             emit_hit;
    logic             unused_in_bits;

    // Only the marker bit and the vertex ID are meaningful in a FIFO word.
    assign unused_in_bits = ^in_dout[62:VID_W];

    // Pops are gated by reset so nothing leaves the upstream FIFO mid-reset.
    assign fetch_go  = (state_q == S_FETCH) && !init_we && in_empty_n && !reset;
    assign in_read   = fetch_go;
    assign out_write = (state_q == S_EMIT) && out_full_n && !reset;
    assign done      = out_write && mark_q;
    assign busy      = (state_q != S_FETCH);
    assign out_din   = out_din_q;
    assign peel_count = peel_q;

    // Saturating decrement; the emit test uses the pre-decrement degree.
    assign new_deg  = (rdata_q == '0) ? '0 : rdata_q - 1'b1;
    assign emit_hit = (k_value != '0) && (rdata_q == k_value);

    // Single RAM port steering: init load or fetch read, re-read, update write.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = vid_q;
        ram_wdata = new_deg;
        case (state_q)
            S_FETCH: begin
                ram_addr  = init_we ? init_addr : in_dout[VID_W-1:0];
                ram_wdata = init_deg;
                ram_we    = init_we;
            end
            S_UPD:   ram_we = (rdata_q != '0);
            default: ;
        endcase
        if (reset) ram_we = 1'b0;
    end

    // Degree RAM: synchronous read, write-first, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_addr] <= ram_wdata;
        rdata_q <= ram_we ? ram_wdata : mem_q[ram_addr];
    end

    // Control FSM with registered output word and peel counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            vid_q     <= '0;
            mark_q    <= 1'b0;
            out_din_q <= '0;
            peel_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fetch_go) begin
                        vid_q  <= in_dout[VID_W-1:0];
                        mark_q <= in_dout[63];
                        if (in_dout[63]) begin
                            out_din_q <= MARKER_WORD;
                            state_q   <= S_EMIT;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: state_q <= S_UPD;
                S_UPD: begin
                    if (emit_hit) begin
                        out_din_q <= {{(64-VID_W){1'b0}}, vid_q};
                        state_q   <= S_EMIT;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_EMIT: begin
                    if (out_full_n) begin
                        if (!mark_q) peel_q <= peel_q + 32'd1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_kcore_degree_update.sv
// Bench for kernel_kcore_degree_update: directed cases plus a randomized
// run checked against an array-based degree model.
module tb_kernel_kcore_degree_update;

    localparam int VID_W = 10;
    localparam int DEG_W = 16;
    localparam logic [63:0] VMASK  = (64'd1 << VID_W) - 64'd1;
    localparam logic [63:0] MARKER = 64'h8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DEG_W-1:0] k_value = '0;
    logic             init_we = 1'b0;
    logic [VID_W-1:0] init_addr = '0;
    logic [DEG_W-1:0] init_deg = '0;
    logic             in_empty_n = 1'b0;
    logic             in_read;
    logic [63:0]      in_dout = '0;
    logic             out_full_n = 1'b1;
    logic             out_write;
    logic [63:0]      out_din;
    logic             busy;
    logic             done;
    logic [31:0]      peel_count;

    int tests = 0;
    int fails = 0;

    logic [DEG_W-1:0] deg_m [2**VID_W];
    logic [DEG_W-1:0] k_m = '0;
    int unsigned      peel_m = 0;

    always #5 clk = ~clk;

    kernel_kcore_degree_update #(.VID_W(VID_W), .DEG_W(DEG_W)) dut (
        .clk(clk), .reset(reset), .k_value(k_value),
        .init_we(init_we), .init_addr(init_addr), .init_deg(init_deg),
        .in_empty_n(in_empty_n), .in_read(in_read), .in_dout(in_dout),
        .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din),
        .busy(busy), .done(done), .peel_count(peel_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input int d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a[VID_W-1:0]; init_deg = d[DEG_W-1:0];
        @(negedge clk);
        init_we = 1'b0;
        deg_m[a] = d[DEG_W-1:0];
    endtask

    task automatic set_k(input int k);
        k_value = k[DEG_W-1:0];
        k_m     = k[DEG_W-1:0];
    endtask

    // Offers one word, holds the output side full for 'stall' cycles after
    // the UPD slot, and records what came out until the block is idle again.
    task automatic run_entry(input logic [63:0] w, input int stall, input logic [63:0] exp_word,
                             output int n_rd, output int n_wr, output logic [63:0] wword,
                             output int lat, output int n_done, output int held);
        int  cyc = 0;
        int  t_rd = 0;
        bit  started = 0;
        bit  fin = 0;
        n_rd = 0; n_wr = 0; n_done = 0; held = 0; lat = -1; wword = '0;
        while (!fin && cyc < 80) begin
            @(negedge clk);
            in_dout    = w;
            in_empty_n = !started;
            out_full_n = !(started && stall > 0 && (cyc - t_rd) <= 2 + stall);
            #1;
            if (in_read) begin
                n_rd++;
                if (!started) t_rd = cyc;
                started = 1;
            end
            if (out_write) begin
                n_wr++; wword = out_din; lat = cyc - t_rd;
            end
            if (done) n_done++;
            if (started && (cyc - t_rd) >= 3 && busy && !out_write && out_din === exp_word) held++;
            if (started && cyc > t_rd && !busy) fin = 1;
            cyc++;
        end
        in_empty_n = 1'b0;
        out_full_n = 1'b1;
        chk("entry_finished", {63'd0, fin}, 64'd1);
    endtask

    task automatic push_v(input int v, input int stall, input logic [63:0] junk);
        logic [63:0]      w, wword;
        logic [DEG_W-1:0] old;
        bit               e;
        int               n_rd, n_wr, lat, n_done, held;
        w   = (junk & ~VMASK & ~MARKER) | (64'(v) & VMASK);
        old = deg_m[v];
        e   = (k_m != 0) && (old == k_m);
        deg_m[v] = (old == 0) ? '0 : old - 1'b1;
        if (e) peel_m++;
        run_entry(w, stall, 64'(v), n_rd, n_wr, wword, lat, n_done, held);
        chk("v_in_read_count", 64'(n_rd), 64'd1);
        chk("v_out_write_count", 64'(n_wr), 64'(e));
        if (e) begin
            chk("v_out_din", wword, 64'(v));
            chk("v_latency", 64'(lat), 64'(3 + stall));
            chk("v_held_cycles", 64'(held), 64'(stall));
        end
        chk("v_done", 64'(n_done), 64'd0);
        chk("v_ram", 64'(dut.mem_q[v]), 64'(deg_m[v]));
        chk("v_peel", 64'(peel_count), 64'(peel_m));
    endtask

    task automatic push_marker();
        logic [63:0] wword;
        int          n_rd, n_wr, lat, n_done, held;
        run_entry(MARKER, 0, MARKER, n_rd, n_wr, wword, lat, n_done, held);
        chk("m_in_read_count", 64'(n_rd), 64'd1);
        chk("m_out_write_count", 64'(n_wr), 64'd1);
        chk("m_out_din", wword, MARKER);
        chk("m_done_pulses", 64'(n_done), 64'd1);
        chk("m_latency", 64'(lat), 64'd1);
        chk("m_peel", 64'(peel_count), 64'(peel_m));
    endtask

    initial begin
        int w;
        for (int i = 0; i < 2**VID_W; i++) deg_m[i] = '0;
        for (int i = 0; i < 16; i++) load(i, 0);

        // Reset state, with a word offered so the pop gating is exercised.
        reset = 1'b1; in_empty_n = 1'b1; in_dout = 64'h5;
        @(negedge clk); #1;
        chk("rst_in_read", 64'(in_read), 64'd0);
        chk("rst_out_write", 64'(out_write), 64'd0);
        chk("rst_out_din", out_din, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_peel", 64'(peel_count), 64'd0);
        @(negedge clk);
        reset = 1'b0; in_empty_n = 1'b0;
        peel_m = 0;

        // Crossing at k: vid 5 emitted, degree 3 -> 2.
        load(5, 3); set_k(3);
        push_v(5, 0, 64'h0);

        // Degree below k never emits; decrement saturates at zero.
        load(7, 2);
        push_v(7, 0, 64'h0);
        push_v(7, 0, 64'h0);
        push_v(7, 0, 64'h0);

        // Backpressure: word held for 10 cycles, then a single write.
        load(9, 4); set_k(4);
        push_v(9, 10, 64'h0);
        chk("bp_idle", 64'(busy), 64'd0);

        // End-of-stream marker.
        push_marker();

        // Init load wins over a pending pop in the same cycle.
        @(negedge clk);
        init_we = 1'b1; init_addr = 10'd20; init_deg = 16'd6;
        in_empty_n = 1'b1; in_dout = 64'd20;
        #1;
        chk("init_prio_no_read", 64'(in_read), 64'd0);
        @(negedge clk);
        init_we = 1'b0;
        #1;
        chk("init_prio_read_next", 64'(in_read), 64'd1);
        deg_m[20] = 16'd5;
        @(negedge clk);
        in_empty_n = 1'b0;
        w = 0;
        do begin @(negedge clk); #1; w++; end while (busy && w < 10);
        chk("init_prio_idle", 64'(busy), 64'd0);
        chk("init_prio_ram", 64'(dut.mem_q[20]), 64'(deg_m[20]));

        // Randomized mix of loads, k changes, vertices and markers.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)       load($urandom_range(0, 15), $urandom_range(0, 7));
            else if (r == 2) set_k($urandom_range(0, 6));
            else if (r == 3) push_marker();
            else             push_v($urandom_range(0, 15), ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0,
                                    {$urandom, $urandom});
        end

        // Reset while the vid 3 update is pending: no write, no output.
        load(3, 4); set_k(4);
        @(negedge clk);
        in_empty_n = 1'b1; in_dout = 64'd3;
        #1;
        chk("mid_rst_read", 64'(in_read), 64'd1);
        @(negedge clk);
        in_empty_n = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_no_write", 64'(out_write), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        peel_m = 0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_peel", 64'(peel_count), 64'(peel_m));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("mid_rst_quiet", 64'(out_write), 64'd0);
        end
        chk("mid_rst_ram", 64'(dut.mem_q[3]), 64'(deg_m[3]));

        // Block still works after the mid-flight reset.
        push_v(3, 0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
